// File: rtl/cfg_delay_line.sv
// cfg_delay_line: multi-channel delay line with run-time selectable latency.
// Aligns operands across all BFU lanes to a programmable latency of
// 0..MAX_DEPTH cycles, with a stall enable, a synchronous flush and
// per-sample valid tracking.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         shift enable (0 = hold every stage)
//   flush      synchronous clear of all stages, valid bits and depth_err
//   depth_sel  requested latency in cycles (values above MAX_DEPTH clamp)
//   din        CH samples, channel k at [k*DATA_W +: DATA_W]
//   din_valid  input sample valid
//   dout       delayed samples (combinational tap)
//   dout_valid valid aligned with dout (combinational tap)
//   busy       any valid sample held in the active stages (combinational)
//   depth_err  sticky registered flag: an out-of-range depth_sel was sampled
module cfg_delay_line #(
  parameter int unsigned DATA_W    = 14,
  parameter int unsigned CH        = 4,
  parameter int unsigned MAX_DEPTH = 8,
  parameter int unsigned SEL_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic [SEL_W-1:0]     depth_sel,
  input  logic [CH*DATA_W-1:0] din,
  input  logic                 din_valid,
  output logic [CH*DATA_W-1:0] dout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 depth_err
);

  localparam int unsigned W = CH * DATA_W;

  logic [W-1:0]         data_q [MAX_DEPTH];
  logic [W-1:0]         data_d [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] vld_q;
  logic [MAX_DEPTH-1:0] vld_d;
  logic                 err_q;
  logic                 err_d;
  logic                 depth_over;
  logic [SEL_W-1:0]     eff_depth;

  // Clamp the requested latency to the physical stage count.
  always_comb begin
    depth_over = (depth_sel > SEL_W'(MAX_DEPTH));
    eff_depth  = depth_over ? SEL_W'(MAX_DEPTH) : depth_sel;
  end

  // Next-state: flush beats shift, shift beats hold.
  always_comb begin
    for (int unsigned s = 0; s < MAX_DEPTH; s++) begin
      data_d[s] = data_q[s];
    end
    vld_d = vld_q;
    err_d = err_q | depth_over;
    if (flush) begin
      for (int unsigned s = 0; s < MAX_DEPTH; s++) begin
        data_d[s] = '0;
      end
      vld_d = '0;
      err_d = 1'b0;
    end else if (en) begin
      data_d[0] = din;
      vld_d[0]  = din_valid;
      for (int unsigned s = 1; s < MAX_DEPTH; s++) begin
        data_d[s] = data_q[s-1];
        vld_d[s]  = vld_q[s-1];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < MAX_DEPTH; s++) begin
        data_q[s] <= '0;
      end
      vld_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < MAX_DEPTH; s++) begin
        data_q[s] <= data_d[s];
      end
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  // Output tap and occupancy; depth 0 is a straight pass-through of din.
  always_comb begin
    dout       = din;
    dout_valid = din_valid;
    busy       = 1'b0;
    for (int unsigned s = 0; s < MAX_DEPTH; s++) begin
      if (eff_depth == SEL_W'(s + 1)) begin
        dout       = data_q[s];
        dout_valid = vld_q[s];
      end
      if (SEL_W'(s) < eff_depth) begin
        busy = busy | vld_q[s];
      end
    end
  end

  assign depth_err = err_q;

endmodule

// File: tb/tb_cfg_delay_line.sv
module tb_cfg_delay_line;

  localparam int unsigned DATA_W    = 14;
  localparam int unsigned CH        = 4;
  localparam int unsigned MAX_DEPTH = 8;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned W         = CH * DATA_W;

  logic             clk;
  logic             rst;
  logic             en;
  logic             flush;
  logic [SEL_W-1:0] depth_sel;
  logic [W-1:0]     din;
  logic             din_valid;
  logic [W-1:0]     dout;
  logic             dout_valid;
  logic             busy;
  logic             depth_err;

  int pass_cnt = 0;
  int total    = 0;

  cfg_delay_line #(
    .DATA_W   (DATA_W),
    .CH       (CH),
    .MAX_DEPTH(MAX_DEPTH),
    .SEL_W    (SEL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .depth_sel (depth_sel),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .depth_err (depth_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample n: channel k carries 0x100*k + n + 1.
  function automatic logic [W-1:0] mk(input int n);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < int'(CH); k++) begin
      r[k*DATA_W +: DATA_W] = DATA_W'(256 * k + n + 1);
    end
    return r;
  endfunction

  task automatic do_flush();
    flush     = 1'b1;
    en        = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; depth_sel = 4'd8;
    din = '0; din_valid = 1'b0;
    #3;
    total++;
    if (dout !== '0 || dout_valid !== 1'b0 || busy !== 1'b0 || depth_err !== 1'b0) begin
      $display("FAIL reset_pre dout=%h v=%b busy=%b err=%b required 0/0/0/0", dout, dout_valid, busy, depth_err);
    end else pass_cnt++;
    en = 1'b1; din = mk(5); din_valid = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (dout !== '0 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_hold dout=%h v=%b busy=%b required 0/0/0", dout, dout_valid, busy);
    end else pass_cnt++;
    #1;
    rst = 1'b0;
  endtask

  // Feed samples 0..cnt-1 at consecutive edges and check the tap after each.
  task automatic test_latency(input int sel, input int d, input int cnt);
    depth_sel = SEL_W'(sel);
    en        = 1'b1;
    flush     = 1'b0;
    din       = mk(0);
    din_valid = 1'b1;
    for (int n = 0; n < cnt; n++) begin
      @(posedge clk);
      #1;
      din = mk(n + 1);
      #1;
      total++;
      if (n >= d - 1) begin
        if (dout !== mk(n - d + 1) || dout_valid !== 1'b1) begin
          $display("FAIL lat%0d edge=%0d dout=%h v=%b required %h/1", d, n, dout, dout_valid, mk(n - d + 1));
        end else pass_cnt++;
      end else begin
        if (dout !== '0 || dout_valid !== 1'b0) begin
          $display("FAIL lat%0d_fill edge=%0d dout=%h v=%b required 0/0", d, n, dout, dout_valid);
        end else pass_cnt++;
      end
      total++;
      if (busy !== 1'b1 || depth_err !== (sel > int'(MAX_DEPTH))) begin
        $display("FAIL lat%0d_flags edge=%0d busy=%b err=%b required 1/%b", d, n, busy, depth_err, sel > int'(MAX_DEPTH));
      end else pass_cnt++;
    end
  endtask

  task automatic test_depth0();
    depth_sel = 4'd0;
    for (int i = 0; i < 4; i++) begin
      din       = W'({$urandom(), $urandom()});
      din_valid = (i % 2) == 1;
      en        = i < 2;
      #1;
      total++;
      if (dout !== din || dout_valid !== din_valid || busy !== 1'b0) begin
        $display("FAIL depth0 i=%0d dout=%h v=%b busy=%b required %h/%b/0", i, dout, dout_valid, busy, din, din_valid);
      end else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    int sh;
    int nxt;
    int idx;
    logic en_next;
    do_flush();
    depth_sel = 4'd4;
    en = 1'b1; din = mk(0); din_valid = 1'b1;
    sh = 0; nxt = 1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (en) sh++;
      en_next = !((c + 1) >= 5 && (c + 1) <= 7);
      if (en_next) begin
        din = mk(nxt);
        nxt++;
      end else begin
        din = '1;
      end
      en = en_next;
      #1;
      idx = sh - 4;
      total++;
      if (idx >= 0) begin
        if (dout !== mk(idx) || dout_valid !== 1'b1) begin
          $display("FAIL stall edge=%0d dout=%h v=%b required %h/1", c, dout, dout_valid, mk(idx));
        end else pass_cnt++;
      end else begin
        if (dout_valid !== 1'b0) begin
          $display("FAIL stall_fill edge=%0d v=%b required 0", c, dout_valid);
        end else pass_cnt++;
      end
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] exp_d;
    do_flush();
    depth_sel = 4'd8;
    en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      din = mk(c); din_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    flush = 1'b1; din = mk(99); din_valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; din = mk(50); din_valid = 1'b1;
    #1;
    total++;
    if (dout !== '0 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL flush_clear dout=%h v=%b busy=%b required 0/0/0", dout, dout_valid, busy);
    end else pass_cnt++;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) begin
        din = '0; din_valid = 1'b0;
      end
      #1;
      exp_d = (j == 7) ? mk(50) : '0;
      total++;
      if (dout !== exp_d || dout_valid !== (j == 7)) begin
        $display("FAIL flush_refill j=%0d dout=%h v=%b required %h/%b", j, dout, dout_valid, exp_d, j == 7);
      end else pass_cnt++;
    end
  endtask

  task automatic test_clamp();
    do_flush();
    depth_sel = 4'd15;
    #1;
    total++;
    if (depth_err !== 1'b0) begin
      $display("FAIL clamp_pre err=%b required 0", depth_err);
    end else pass_cnt++;
    test_latency(15, 8, 10);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    depth_sel = 4'd8;
    #1;
    total++;
    if (depth_err !== 1'b0 || dout_valid !== 1'b0) begin
      $display("FAIL clamp_flush err=%b v=%b required 0/0", depth_err, dout_valid);
    end else pass_cnt++;
    @(posedge clk);
    #1;
    total++;
    if (depth_err !== 1'b0) begin
      $display("FAIL clamp_stay err=%b required 0", depth_err);
    end else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_flush();
    test_latency(4, 4, 6);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (dout !== '0 || dout_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL async_rst dout=%h v=%b busy=%b required 0/0/0", dout, dout_valid, busy);
    end else pass_cnt++;
    @(posedge clk);
    #2;
    rst = 1'b0;
    test_latency(4, 4, 10);
  endtask

  initial begin
    test_reset();
    test_latency(8, 8, 16);
    do_flush();
    test_depth0();
    do_flush();
    test_latency(4, 4, 12);
    do_flush();
    test_latency(7, 7, 12);
    test_stall();
    test_flush();
    test_clamp();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
